avl_arbiter: RTL
================

// Module: avl_arbiter
// PURPOSE
//  Shares the single Avalon-MM bridge request port (valid/instr/addr/wdata/wstrb -> rdata/ready)
//  between instruction fetch (port I) and data load/store (port D). Requests are single-cycle
//  valid pulses; a request losing arbitration or arriving while the bridge is busy is buffered.
//  Exactly one transaction is outstanding at the bridge; the response is routed to its owner.
// PARAMETERS
//  FIXED_PRIO  0  0: round-robin between I and D; 1: D always wins simultaneous contention
// PORTS
//  clk          in   1   clock; all state on rising edge
//  rst          in   1   synchronous, active-low reset
//  i_valid      in   1   port I request pulse (read only)
//  i_addr       in   32  port I byte address
//  i_rdata      out  32  port I read data, valid with i_ready
//  i_ready      out  1   port I completion pulse
//  d_valid      in   1   port D request pulse
//  d_addr       in   32  port D byte address
//  d_wdata      in   32  port D write data
//  d_wstrb      in   4   port D byte strobes; 0 = load
//  d_rdata      out  32  port D read data, valid with d_ready (0 on stores)
//  d_ready      out  1   port D completion pulse
//  avl_valid    out  1   request pulse to bridge
//  avl_instr    out  1   1 = current request owned by port I
//  avl_addr     out  32  request address
//  avl_wdata    out  32  request write data (0 for port I)
//  avl_wstrb    out  4   request strobes (0 for port I)
//  avl_rdata    in   32  bridge read data
//  avl_ready    in   1   bridge completion pulse
// BEHAVIOUR
//  - States: IDLE (no outstanding request), BUSY (one request issued, awaiting avl_ready).
//  - Pending buffers: one per port {pend, addr, wdata, wstrb}. Candidate for a port = pending entry
//    if pend=1, else live valid input. Live valid captured into buffer when not granted this cycle.
//  - IDLE: if any candidate, grant combinationally in the same cycle: avl_valid=1, fields from winner,
//    -> BUSY, owner<=winner, winner's pend cleared. Zero added latency for an uncontended request.
//  - Arbitration: only one candidate -> it wins. Both -> FIXED_PRIO=1: D; FIXED_PRIO=0: port not
//    granted last (last_grant flop, reset value = I, so D wins first contention after reset).
//  - BUSY: avl_valid=0. On avl_ready=1: pulse owner's ready with avl_rdata (other port ready=0,
//    rdata=0), -> IDLE. Next grant earliest the following cycle (bridge re-enters idle then).
//  - Live valid during BUSY, or losing in IDLE, or on the avl_ready cycle -> latched into its buffer.
//  - A port issues no new valid until its ready; a valid while its own request pends/is in flight
//    is a protocol violation, ignored (buffer not overwritten); bench asserts it never occurs.
//  - All outputs 0 when not actively driven (avl_* fields 0 unless avl_valid=1).
//  - Reset (rst=0): state IDLE, pend=0 both, last_grant=I, owner=I; outputs combinationally 0
//    during reset; inputs ignored. Reset mid-transaction drops the outstanding request and both
//    buffers; no ready is delivered for them (bridge is reset on the same rst).
//  - avl_ready in IDLE (spurious) is ignored; no requester ready produced.
//  - Latency: uncontended request -> avl_valid same cycle; requester ready same cycle as avl_ready.
// STRUCTURE
//  - configure package: arbiter state enum (IDLE/BUSY), port id constants (PORT_I=0, PORT_D=1),
//    request struct {addr[31:0], wdata[31:0], wstrb[3:0]}.
//  - Sub-module avl_arb_slot: one pending buffer (capture/clear/hold); instantiated twice.
//  - Top: grant logic, state/owner/last_grant flops, response demux. Two-process comb/ff style.
// TESTING
//  1. Single I fetch addr 0x100 in IDLE -> avl_valid=1,avl_instr=1 same cycle; avl_ready w/ rdata
//     0xDEADBEEF -> i_ready=1,i_rdata=0xDEADBEEF that cycle; d_ready=0.
//  2. Simultaneous I(0x200) and D store (0x300,wdata 0x12345678,wstrb 0xF) after reset,
//     FIXED_PRIO=0 -> D granted first, I buffered and issued cycle after D's avl_ready, avl_instr=1.
//  3. Repeated simultaneous contention x4, FIXED_PRIO=0 -> grants alternate D,I,D,I...;
//     FIXED_PRIO=1 -> D wins each contended cycle.
//  4. D load pulse while I in flight -> buffered; on I's avl_ready i_ready only, D issued next
//     cycle with original addr/wstrb=0; d_ready carries its rdata.
//  5. Reset (rst=0) while BUSY with D pending -> all outputs 0; after release no i/d_ready;
//     fresh I request issues cleanly.
//  6. Spurious avl_ready in IDLE -> i_ready=d_ready=0, state unchanged.

Source files
------------

// File: rtl/avl_arbiter_pkg.sv
// Shared types for the two-port Avalon-MM request arbiter: FSM states,
// port identifiers and the buffered request payload.
package avl_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

endpackage

// File: rtl/avl_arb_slot.sv
// One pending-request buffer: captures a request that could not be issued
// immediately, holds it, and drops it when the arbiter issues it.
module avl_arb_slot
    import avl_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic capture_i,
    input  logic clear_i,
    input  req_t req_i,
    output logic pend_o,
    output req_t req_o
);

    logic pend_q, pend_d;
    req_t req_q, req_d;

    // NOTE: every variable gets its hold value before any branch, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        pend_d = pend_q;
        req_d  = req_q;
        if (clear_i) begin
            pend_d = 1'b0;
        end else if (capture_i) begin
            pend_d = 1'b1;
            req_d  = req_i;
        end
    end

    // NOTE: flops use non-blocking assignments so all of them update from pre-edge values, independent of block order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pend_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
        end
    end

    // NOTE: the payload is deliberately left unreset; it is only ever read while pend_q is set.
    always_ff @(posedge clk) begin
        req_q <= req_d;
    end

    assign pend_o = pend_q;
    assign req_o  = req_q;

endmodule

// File: rtl/avl_arbiter.sv
// Shares one Avalon-MM bridge request port between instruction fetch (I)
// and data load/store (D), with one outstanding transaction at a time.
module avl_arbiter
    import avl_arbiter_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_valid,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ready,
    input  logic        d_valid,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        avl_valid,
    output logic        avl_instr,
    output logic [31:0] avl_addr,
    output logic [31:0] avl_wdata,
    output logic [3:0]  avl_wstrb,
    input  logic [31:0] avl_rdata,
    input  logic        avl_ready
);

    arb_state_e state_q, state_d;
    logic       owner_q, owner_d;
    logic       last_grant_q, last_grant_d;
    logic       store_q, store_d;

    logic i_pend, d_pend;
    req_t i_buf, d_buf, i_live, d_live, i_cand_req, d_cand_req, win_req;
    logic i_cand, d_cand, winner, grant, i_grant, d_grant, i_cap, d_cap, done;

    always_comb begin
        i_live       = '0;
        i_live.addr  = i_addr;
        d_live.addr  = d_addr;
        d_live.wdata = d_wdata;
        d_live.wstrb = d_wstrb;

        i_cand     = i_pend | i_valid;
        d_cand     = d_pend | d_valid;
        i_cand_req = i_pend ? i_buf : i_live;
        d_cand_req = d_pend ? d_buf : d_live;

        // Round-robin favours the port that did not win the previous grant.
        winner = PORT_I;
        if (i_cand && d_cand) begin
            winner = (FIXED_PRIO || last_grant_q == PORT_I) ? PORT_D : PORT_I;
        end else if (d_cand) begin
            winner = PORT_D;
        end
        win_req = (winner == PORT_D) ? d_cand_req : i_cand_req;

        grant   = rst && (state_q == IDLE) && (i_cand || d_cand);
        i_grant = grant && (winner == PORT_I);
        d_grant = grant && (winner == PORT_D);
        done    = rst && (state_q == BUSY) && avl_ready;

        // A valid from a port whose own request is still pending or in flight is dropped.
        i_cap = rst && i_valid && !i_pend && !i_grant && !((state_q == BUSY) && (owner_q == PORT_I));
        d_cap = rst && d_valid && !d_pend && !d_grant && !((state_q == BUSY) && (owner_q == PORT_D));
    end

    avl_arb_slot u_slot_i (
        .clk       (clk),
        .rst       (rst),
        .capture_i (i_cap),
        .clear_i   (i_grant && i_pend),
        .req_i     (i_live),
        .pend_o    (i_pend),
        .req_o     (i_buf)
    );

    avl_arb_slot u_slot_d (
        .clk       (clk),
        .rst       (rst),
        .capture_i (d_cap),
        .clear_i   (d_grant && d_pend),
        .req_i     (d_live),
        .pend_o    (d_pend),
        .req_o     (d_buf)
    );

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        store_d      = store_q;
        if (grant) begin
            state_d      = BUSY;
            owner_d      = winner;
            last_grant_d = winner;
            store_d      = (winner == PORT_D) && (win_req.wstrb != 4'b0);
        end else if (done) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            owner_q      <= PORT_I;
            last_grant_q <= PORT_I;
            store_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            store_q      <= store_d;
        end
    end

    always_comb begin
        avl_valid = 1'b0;
        avl_instr = 1'b0;
        avl_addr  = '0;
        avl_wdata = '0;
        avl_wstrb = '0;
        i_ready   = 1'b0;
        i_rdata   = '0;
        d_ready   = 1'b0;
        d_rdata   = '0;
        if (grant) begin
            avl_valid = 1'b1;
            avl_instr = (winner == PORT_I);
            avl_addr  = win_req.addr;
            avl_wdata = win_req.wdata;
            avl_wstrb = win_req.wstrb;
        end
        // Stores complete with zero read data regardless of what the bridge returns.
        if (done) begin
            if (owner_q == PORT_D) begin
                d_ready = 1'b1;
                d_rdata = store_q ? 32'h0 : avl_rdata;
            end else begin
                i_ready = 1'b1;
                i_rdata = avl_rdata;
            end
        end
    end

endmodule
